sys_arr_feeder: RTL and testbench
=================================

Name: sys_arr_feeder

Overview:
- Upstream sequencer for the systolic array: takes one GEMM command at a time and bursts weight rows, then input and partial-sum rows, into the array-side port.
- Enforces the array's burst contract: weight_en and partial_en held exactly N consecutive cycles. Gates bursts on drained/fifo_has_space and tracks in-flight GEMMs until their last output row.
- Sits between the scratchpad row readers and the array's memory-facing port.

Parameters:
N, 32, array dimension (rows per burst, elements per row)
DW, 16, element width in bits
MAX_INFLIGHT, 4, GEMMs streamed but not yet fully output

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  GEMM command valid
cmd_ready  out  1  feeder can accept a command
cmd_reuse_w  in  1  skip weight load and reuse resident weights
cmd_has_ps  in  1  partial sums supplied; if 0, no partial burst
w_burst_avail, x_burst_avail, p_burst_avail  in  1 each  N full rows buffered upstream for weights/inputs/partials
w_valid, x_valid, p_valid  in  1 each  row valid
w_data, x_data, p_data  in  DW*N each  row data
w_ready, x_ready, p_ready  out  1 each  row consumed this cycle
weight_en, input_en, partial_en  out  1 each  array bus qualifiers
row_in_en, row_ps_en  out  $clog2(N)  row index for array_in / array_in_partials
array_in, array_in_partials  out  DW*N  row data to array
drained, fifo_has_space, out_en  in  1 each  array status
row_out  in  $clog2(N)  row currently output by the array
busy  out  1  state != IDLE or inflight != 0
gemm_done  out  1  one-cycle pulse on a GEMM's final output row
inflight  out  $clog2(MAX_INFLIGHT+1)  current in-flight count
underrun  out  1  sticky protocol error
err_clr  in  1  clears underrun

Behaviour:
- Reset: single clock clk; rst is synchronous, active-high.
  - While rst is high: state=IDLE, inflight=0, underrun=0, all array-side outputs 0, all *_ready 0, gemm_done 0, cmd_ready 0.
  - A mid-burst reset truncates the burst immediately; no recovery of partial bursts.
- FSM states: IDLE, WAIT_W, LOAD_W, WAIT_X, STREAM.
  - IDLE: cmd_ready=1. On cmd_valid, latch reuse_w/has_ps. Go to WAIT_X if reuse_w, else WAIT_W.
  - WAIT_W: go to LOAD_W when drained && w_burst_avail.
  - LOAD_W: exactly N cycles, counter k=0..N-1. w_ready=1 every cycle (combinational on state). Then go to WAIT_X.
  - WAIT_X: go to STREAM when all of the following hold:
    - fifo_has_space
    - x_burst_avail
    - (p_burst_avail || !has_ps)
    - inflight < MAX_INFLIGHT
  - STREAM: exactly N cycles. x_ready=1, and p_ready=has_ps. On the last cycle inflight increments and the next state is IDLE.
- Array-side outputs are registered, so the row consumed in cycle t appears at t+1.
  - LOAD_W: weight_en=1, row_in_en=k.
  - STREAM: input_en=1, row_in_en=k; partial_en=has_ps, row_ps_en=k.
  - Data outputs are zero whenever their enable is low.
- Burst lengths:
  - weight_en is high exactly N consecutive cycles per load.
  - input_en and partial_en are high exactly N consecutive cycles per GEMM.
  - No gap inside a burst under any stimulus.
- Underrun: a phase cycle with the relevant *_valid=0 still advances k and keeps the enable high. That row's data is driven as zero and underrun is set. err_clr clears underrun; if a set and err_clr occur in the same cycle, the set wins.
- Completion: out_en && row_out==N-1 pulses gemm_done next cycle and decrements inflight.
  - Increment and decrement in the same cycle leave inflight unchanged.
  - A decrement at inflight=0 is ignored and sets underrun.
- cmd_ready is low outside IDLE; back-to-back commands therefore have at least one IDLE cycle between them.
- Minimum latency with reuse_w=0 and all conditions true: cmd accepted at cycle 0 → weight_en high cycles 3..N+2 → input_en high from cycle N+4.

Decomposition:
- sys_arr_pkg holds:
  - N, DW
  - row_t (logic [DW*N-1:0]), row_idx_t (logic [$clog2(N)-1:0])
  - feeder_state_t enum
- One sub-module, sys_arr_burst_ctr: start pulse, counts 0..N-1, outputs idx, active, last. Instantiated once and shared by LOAD_W and STREAM.

Test Plan:
- Reset then cmd (reuse_w=0, has_ps=1), all avail/valid=1, drained=1, fifo_has_space=1, w_data row k=k → weight_en high exactly 32 cycles, row_in_en 0..31, array_in=k one cycle after w_ready; then input_en and partial_en high exactly 32 cycles together.
- cmd with reuse_w=1, has_ps=0 → no weight_en, input_en 32 cycles, partial_en never asserts, p_ready stays 0.
- drained=0 for 10 cycles after cmd → stay in WAIT_W, weight_en=0; burst starts the cycle after drained rises, still 32 contiguous cycles.
- Issue 4 GEMMs with no out_en → inflight=4, 5th command waits in WAIT_X. Then pulse out_en with row_out=31 → gemm_done pulse, inflight=3, 5th streams.
- w_valid low at row 7 → weight_en stays high, array_in=0 for row 7, underrun=1 until err_clr.
- rst asserted at row 15 of STREAM → next cycle all enables 0, inflight=0, cmd_ready=0 during rst, 1 the cycle after release.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared types and dimensions for the systolic-array feeder.
package sys_arr_pkg;
  localparam int N    = 32;
  localparam int DW   = 16;
  localparam int IDXW = $clog2(N);

  typedef logic [DW*N-1:0] row_t;
  typedef logic [IDXW-1:0] row_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    LOAD_W,
    WAIT_X,
    STREAM
  } feeder_state_t;
endpackage

// File: rtl/sys_arr_burst_ctr.sv
// Row counter for one N-row burst: start pulse, then idx walks 0..N-1.
module sys_arr_burst_ctr
  import sys_arr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic [IDXW-1:0] idx_o,
  output logic            active_o,
  output logic            last_o
);
  localparam row_idx_t LAST_IDX = row_idx_t'(N - 1);

  row_idx_t idx_q, idx_d;
  logic     active_q, active_d;

  always_comb begin
    idx_d    = idx_q;
    active_d = active_q;
    if (start_i) begin
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign idx_o    = idx_q;
  assign active_o = active_q;
  assign last_o   = active_q && (idx_q == LAST_IDX);
endmodule

// File: rtl/sys_arr_feeder.sv
// GEMM command sequencer: bursts weight rows, then input/partial rows, into the array
// and tracks GEMMs in flight until their last output row leaves the array.
module sys_arr_feeder
  import sys_arr_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_reuse_w,
  input  logic                                cmd_has_ps,
  input  logic                                w_burst_avail,
  input  logic                                x_burst_avail,
  input  logic                                p_burst_avail,
  input  logic                                w_valid,
  input  logic                                x_valid,
  input  logic                                p_valid,
  input  logic [DW*N-1:0]                     w_data,
  input  logic [DW*N-1:0]                     x_data,
  input  logic [DW*N-1:0]                     p_data,
  output logic                                w_ready,
  output logic                                x_ready,
  output logic                                p_ready,
  output logic                                weight_en,
  output logic                                input_en,
  output logic                                partial_en,
  output logic [IDXW-1:0]                     row_in_en,
  output logic [IDXW-1:0]                     row_ps_en,
  output logic [DW*N-1:0]                     array_in,
  output logic [DW*N-1:0]                     array_in_partials,
  input  logic                                drained,
  input  logic                                fifo_has_space,
  input  logic                                out_en,
  input  logic [IDXW-1:0]                     row_out,
  output logic                                busy,
  output logic                                gemm_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                underrun,
  input  logic                                err_clr
);
  localparam int              IFW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IFW-1:0]  MAX_IF   = IFW'(MAX_INFLIGHT);
  localparam row_idx_t        LAST_ROW = row_idx_t'(N - 1);

  feeder_state_t  state_q, state_d;
  logic           reuse_w_q, reuse_w_d, has_ps_q, has_ps_d;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic           underrun_q, underrun_d, gemm_done_q, gemm_done_d;
  logic           weight_en_q, input_en_q, partial_en_q;
  logic           weight_en_d, input_en_d, partial_en_d;
  row_idx_t       row_in_en_q, row_in_en_d, row_ps_en_q, row_ps_en_d;
  row_t           array_in_q, array_in_d, array_ps_q, array_ps_d;

  logic           ctr_start, ctr_active, ctr_last, inc, done, dec_ok, err_set;
  row_idx_t       ctr_idx;

  sys_arr_burst_ctr u_ctr (
    .clk      (clk),
    .rst      (rst),
    .start_i  (ctr_start),
    .idx_o    (ctr_idx),
    .active_o (ctr_active),
    .last_o   (ctr_last)
  );

  always_comb begin
    state_d   = state_q;
    reuse_w_d = reuse_w_q;
    has_ps_d  = has_ps_q;
    ctr_start = 1'b0;
    inc       = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        reuse_w_d = cmd_reuse_w;
        has_ps_d  = cmd_has_ps;
        state_d   = cmd_reuse_w ? WAIT_X : WAIT_W;
      end
      WAIT_W: if (drained && w_burst_avail) begin
        ctr_start = 1'b1;
        state_d   = LOAD_W;
      end
      LOAD_W: if (ctr_last) state_d = WAIT_X;
      WAIT_X: if (fifo_has_space && x_burst_avail && (p_burst_avail || !has_ps_q) &&
                  (inflight_q < MAX_IF)) begin
        ctr_start = 1'b1;
        state_d   = STREAM;
      end
      STREAM: if (ctr_last) begin
        inc     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = !rst && (state_q == IDLE);
  assign w_ready   = !rst && (state_q == LOAD_W);
  assign x_ready   = !rst && (state_q == STREAM);
  assign p_ready   = x_ready && has_ps_q;

  // A completion with nothing in flight is a protocol error, unless a GEMM retires into it.
  assign done    = out_en && (row_out == LAST_ROW);
  assign dec_ok  = done && ((inflight_q != '0) || inc);
  assign err_set = (w_ready && !w_valid) || (x_ready && !x_valid) ||
                   (p_ready && !p_valid) || (done && !dec_ok);

  always_comb begin
    inflight_d = inflight_q;
    if (inc && !dec_ok)      inflight_d = inflight_q + 1'b1;
    else if (!inc && dec_ok) inflight_d = inflight_q - 1'b1;
    gemm_done_d = dec_ok;
    underrun_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : underrun_q);

    weight_en_d  = w_ready;
    input_en_d   = x_ready;
    partial_en_d = p_ready;
    row_in_en_d  = ((w_ready || x_ready) && ctr_active) ? ctr_idx : '0;
    row_ps_en_d  = (p_ready && ctr_active) ? ctr_idx : '0;
    array_in_d   = '0;
    if (w_ready && w_valid)      array_in_d = w_data;
    else if (x_ready && x_valid) array_in_d = x_data;
    array_ps_d   = (p_ready && p_valid) ? p_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      reuse_w_q    <= 1'b0;
      has_ps_q     <= 1'b0;
      inflight_q   <= '0;
      underrun_q   <= 1'b0;
      gemm_done_q  <= 1'b0;
      weight_en_q  <= 1'b0;
      input_en_q   <= 1'b0;
      partial_en_q <= 1'b0;
      row_in_en_q  <= '0;
      row_ps_en_q  <= '0;
      array_in_q   <= '0;
      array_ps_q   <= '0;
    end else begin
      state_q      <= state_d;
      reuse_w_q    <= reuse_w_d;
      has_ps_q     <= has_ps_d;
      inflight_q   <= inflight_d;
      underrun_q   <= underrun_d;
      gemm_done_q  <= gemm_done_d;
      weight_en_q  <= weight_en_d;
      input_en_q   <= input_en_d;
      partial_en_q <= partial_en_d;
      row_in_en_q  <= row_in_en_d;
      row_ps_en_q  <= row_ps_en_d;
      array_in_q   <= array_in_d;
      array_ps_q   <= array_ps_d;
    end
  end

  assign weight_en         = weight_en_q;
  assign input_en          = input_en_q;
  assign partial_en        = partial_en_q;
  assign row_in_en         = row_in_en_q;
  assign row_ps_en         = row_ps_en_q;
  assign array_in          = array_in_q;
  assign array_in_partials = array_ps_q;
  assign gemm_done         = gemm_done_q;
  assign inflight          = inflight_q;
  assign underrun          = underrun_q;
  assign busy              = (state_q != IDLE) || (inflight_q != '0);
endmodule

// File: tb/tb_sys_arr_feeder.sv
// Directed bench for sys_arr_feeder: burst shape, latency, gating, in-flight limit,
// underrun handling and mid-burst reset.
module tb_sys_arr_feeder;
  import sys_arr_pkg::*;

  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_reuse_w, cmd_has_ps;
  logic w_burst_avail, x_burst_avail, p_burst_avail;
  logic w_valid, x_valid, p_valid;
  row_t w_data, x_data, p_data;
  logic w_ready, x_ready, p_ready;
  logic weight_en, input_en, partial_en;
  row_idx_t row_in_en, row_ps_en, row_out;
  row_t array_in, array_in_partials;
  logic drained, fifo_has_space, out_en;
  logic busy, gemm_done, underrun, err_clr;
  logic [2:0] inflight;

  sys_arr_feeder #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reuse_w(cmd_reuse_w), .cmd_has_ps(cmd_has_ps),
    .w_burst_avail(w_burst_avail), .x_burst_avail(x_burst_avail), .p_burst_avail(p_burst_avail),
    .w_valid(w_valid), .x_valid(x_valid), .p_valid(p_valid),
    .w_data(w_data), .x_data(x_data), .p_data(p_data),
    .w_ready(w_ready), .x_ready(x_ready), .p_ready(p_ready),
    .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
    .row_in_en(row_in_en), .row_ps_en(row_ps_en),
    .array_in(array_in), .array_in_partials(array_in_partials),
    .drained(drained), .fifo_has_space(fifo_has_space), .out_en(out_en),
    .row_out(row_out), .busy(busy), .gemm_done(gemm_done), .inflight(inflight),
    .underrun(underrun), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, c = 0;
  int drop_row = -1;
  int wk, xk, pk, prdy;
  int wrun, wlen, wfirst, wbursts, wbad;
  int irun, ilen, ifirst, ibursts, ibad;
  int prun, plen, pfirst, pbursts, pbad, zbad;

  function automatic row_t mkrow(input logic [15:0] v);
    return {N{v}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wk = 0; xk = 0; pk = 0; prdy = 0; zbad = 0;
    wrun = 0; wlen = 0; wfirst = 0; wbursts = 0; wbad = 0;
    irun = 0; ilen = 0; ifirst = 0; ibursts = 0; ibad = 0;
    prun = 0; plen = 0; pfirst = 0; pbursts = 0; pbad = 0;
  endtask

  // One cycle: observe array side at the falling edge, then present next rows.
  task automatic step();
    row_t e;
    @(negedge clk);
    cyc++;
    if (weight_en) begin
      if (wrun == 0) wfirst = cyc;
      e = (wrun == drop_row) ? '0 : mkrow(16'(wrun));
      if (row_in_en !== IDXW'(wrun) || array_in !== e) wbad++;
      wrun++;
    end else if (wrun != 0) begin
      wlen = wrun; wrun = 0; wbursts++;
    end
    if (input_en) begin
      if (irun == 0) ifirst = cyc;
      if (row_in_en !== IDXW'(irun) || array_in !== mkrow(16'h4000 + 16'(irun))) ibad++;
      irun++;
    end else if (irun != 0) begin
      ilen = irun; irun = 0; ibursts++;
    end
    if (partial_en) begin
      if (prun == 0) pfirst = cyc;
      if (row_ps_en !== IDXW'(prun) || array_in_partials !== mkrow(16'h8000 + 16'(prun))) pbad++;
      prun++;
    end else if (prun != 0) begin
      plen = prun; prun = 0; pbursts++;
    end
    if (!weight_en && !input_en && (array_in !== '0 || row_in_en !== '0)) zbad++;
    if (!partial_en && (array_in_partials !== '0 || row_ps_en !== '0)) zbad++;
    if (p_ready) prdy++;
    w_valid = (wk != drop_row);
    w_data  = w_ready ? mkrow(16'(wk)) : mkrow(16'hDEAD);
    if (w_ready) wk++;
    x_data  = x_ready ? mkrow(16'h4000 + 16'(xk)) : mkrow(16'hBEEF);
    if (x_ready) xk++;
    p_data  = p_ready ? mkrow(16'h8000 + 16'(pk)) : mkrow(16'hCAFE);
    if (p_ready) pk++;
  endtask

  task automatic issue(input logic reuse, input logic ps);
    clr();
    c = cyc;
    cmd_valid = 1'b1; cmd_reuse_w = reuse; cmd_has_ps = ps;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_reuse_w = 0; cmd_has_ps = 0;
    w_burst_avail = 0; x_burst_avail = 0; p_burst_avail = 0;
    w_valid = 0; x_valid = 0; p_valid = 0;
    w_data = '0; x_data = '0; p_data = '0;
    drained = 0; fifo_has_space = 0; out_en = 0; row_out = '0; err_clr = 0;
    clr();
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_weight_en", weight_en, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    w_burst_avail = 1; x_burst_avail = 1; p_burst_avail = 1;
    w_valid = 1; x_valid = 1; p_valid = 1;
    drained = 1; fifo_has_space = 1;

    // Full GEMM with weight load and partials.
    issue(1'b0, 1'b1);
    repeat (74) step();
    chk("t1_w_first", wfirst - c, 3);
    chk("t1_w_len", wlen, 32);
    chk("t1_w_bursts", wbursts, 1);
    chk("t1_w_rows", wbad, 0);
    chk("t1_x_first", ifirst - c, 36);
    chk("t1_p_first", pfirst - c, 36);
    chk("t1_x_len", ilen, 32);
    chk("t1_p_len", plen, 32);
    chk("t1_rows", ibad + pbad + zbad, 0);
    chk("t1_inflight", inflight, 1);
    chk("t1_underrun", underrun, 0);
    chk("t1_busy", busy, 1);

    // Reused weights, no partial sums.
    issue(1'b1, 1'b0);
    repeat (39) step();
    chk("t2_no_w", wbursts + wrun, 0);
    chk("t2_x_first", ifirst - c, 3);
    chk("t2_x_len", ilen, 32);
    chk("t2_no_p", pbursts + prun, 0);
    chk("t2_p_ready", prdy, 0);
    chk("t2_inflight", inflight, 2);

    // Array not drained for 10 cycles after the command.
    drained = 0;
    issue(1'b0, 1'b1);
    repeat (10) step();
    chk("t3_hold_w", weight_en, 0);
    chk("t3_hold_ready", w_ready, 0);
    drained = 1;
    repeat (80) step();
    chk("t3_w_first", wfirst - c, 13);
    chk("t3_w_len", wlen, 32);
    chk("t3_x_first", ifirst - c, 46);
    chk("t3_x_len", ilen, 32);
    chk("t3_rows", wbad + ibad + pbad + zbad, 0);
    chk("t3_inflight", inflight, 3);

    // In-flight limit.
    issue(1'b1, 1'b0);
    repeat (39) step();
    chk("t4_inflight_full", inflight, 4);
    issue(1'b1, 1'b0);
    repeat (20) step();
    chk("t4_blocked", ibursts + irun, 0);
    chk("t4_cmd_ready", cmd_ready, 0);
    chk("t4_busy", busy, 1);
    out_en = 1; row_out = 5'd30;
    step();
    out_en = 0;
    chk("t4_row30_done", gemm_done, 0);
    chk("t4_row30_inflight", inflight, 4);
    out_en = 1; row_out = 5'd31;
    step();
    out_en = 0;
    chk("t4_done_pulse", gemm_done, 1);
    chk("t4_inflight_dec", inflight, 3);
    step();
    chk("t4_done_low", gemm_done, 0);
    repeat (40) step();
    chk("t4_x_len", ilen, 32);
    chk("t4_rows", ibad + zbad, 0);
    chk("t4_inflight_back", inflight, 4);

    // Drain, then completion with nothing in flight.
    out_en = 1; row_out = 5'd31;
    repeat (4) step();
    out_en = 0;
    chk("t5_drained", inflight, 0);
    chk("t5_no_err", underrun, 0);
    out_en = 1;
    step();
    out_en = 0;
    chk("t5_dec_at_zero", underrun, 1);
    chk("t5_stay_zero", inflight, 0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("t5_err_clr", underrun, 0);
    out_en = 1; err_clr = 1;
    step();
    out_en = 0; err_clr = 0;
    chk("t5_set_wins", underrun, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("t5_clr2", underrun, 0);

    // Weight row 7 missing.
    drop_row = 7;
    issue(1'b0, 1'b0);
    repeat (8) step();
    chk("t6_before_row7", underrun, 0);
    step();
    chk("t6_row7_err", underrun, 1);
    chk("t6_row7_en", weight_en, 1);
    chk("t6_row7_idx", row_in_en, 7);
    chk("t6_row7_zero", array_in == '0, 1);
    repeat (70) step();
    drop_row = -1;
    chk("t6_w_len", wlen, 32);
    chk("t6_rows", wbad + ibad + zbad, 0);
    chk("t6_sticky", underrun, 1);
    chk("t6_no_p", pbursts, 0);
    chk("t6_inflight", inflight, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("t6_clr", underrun, 0);

    // Reset in the middle of a stream.
    issue(1'b1, 1'b1);
    repeat (16) step();
    rst = 1;
    step();
    chk("t7_input_en", input_en, 0);
    chk("t7_partial_en", partial_en, 0);
    chk("t7_inflight", inflight, 0);
    chk("t7_cmd_ready_rst", cmd_ready, 0);
    chk("t7_x_rows", ilen, 15);
    step();
    chk("t7_cmd_ready_rst2", cmd_ready, 0);
    rst = 0;
    step();
    chk("t7_cmd_ready_rel", cmd_ready, 1);
    chk("t7_busy", busy, 0);
    chk("t7_zero", zbad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
